// File: rtl/cic_comb_sub_pkg.sv
// ---------------------------------------------------------------------------
// cic_comb_sub_pkg
// Shared definitions for the CIC comb section slice:
//   - comb_state_e      : section operating state (S_OFF / S_CLEAR / S_RUN)
//   - CFG_STATE_CLEAR   : system config state value that requests a clear
//   - DEF_*             : default widths / channel count
//   - decode_state()    : priority decode of the section state
// ---------------------------------------------------------------------------
package cic_comb_sub_pkg;

    localparam int DEF_MIDDLE_WIDTH      = 37;
    localparam int DEF_MAX_CHANNELS      = 16;
    localparam int DEF_CONFIG_DATA_WIDTH = 16;
    localparam int CH_IDX_WIDTH          = 4;

    localparam logic [2:0] CFG_STATE_CLEAR = 3'd3;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } comb_state_e;

    // Disabled section beats clear, clear beats run.
    function automatic comb_state_e decode_state(input logic       sec_en,
                                                 input logic [2:0] cfg_state);
        comb_state_e st;
        if (!sec_en) begin
            st = S_OFF;
        end else if (cfg_state == CFG_STATE_CLEAR) begin
            st = S_CLEAR;
        end else begin
            st = S_RUN;
        end
        return st;
    endfunction

endpackage

// File: rtl/cic_comb_sub_delay_bank.sv
// ---------------------------------------------------------------------------
// cic_comb_delay_bank
// Per-channel history slots for the comb section.
//   D1[c] holds the previous sample of channel c, D2[c] the one before it.
//   D2 exists only when CIC_COMB_DIFF_DELAY2_EN is defined; otherwise rd_d2
//   reads as zero.
// Ports:
//   clk      in   clock (rising edge)
//   rst      in   synchronous active-high reset, zeroes all slots
//   clr      in   synchronous clear-all, zeroes all slots
//   wr_en    in   shift wr_data into channel wr_ch (D2 <= D1, D1 <= data)
//   wr_ch    in   channel written
//   wr_data  in   sample written
//   rd_ch    in   channel read
//   rd_d1    out  D1[rd_ch] (zero for an out-of-range channel)
//   rd_d2    out  D2[rd_ch] (zero for an out-of-range channel / no D2)
// Configuration macro: CIC_COMB_DIFF_DELAY2_EN
// ---------------------------------------------------------------------------
module cic_comb_delay_bank
    import cic_comb_sub_pkg::*;
#(
    parameter int W  = DEF_MIDDLE_WIDTH,
    parameter int CH = DEF_MAX_CHANNELS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [CH_IDX_WIDTH-1:0] wr_ch,
    input  logic [W-1:0]            wr_data,
    input  logic [CH_IDX_WIDTH-1:0] rd_ch,
    output logic [W-1:0]            rd_d1,
    output logic [W-1:0]            rd_d2
);

    localparam logic [CH_IDX_WIDTH:0] CH_LIMIT = (CH_IDX_WIDTH + 1)'(CH);

    logic [W-1:0] d1_r [CH];
`ifdef CIC_COMB_DIFF_DELAY2_EN
    logic [W-1:0] d2_r [CH];
`endif

    logic rd_ok_s;

    // Slot storage: reset/clear zero every slot, otherwise shift on write.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < CH; i++) begin
                d1_r[i] <= {W{1'b0}};
`ifdef CIC_COMB_DIFF_DELAY2_EN
                d2_r[i] <= {W{1'b0}};
`endif
            end
        end else if (wr_en) begin
            d1_r[wr_ch] <= wr_data;
`ifdef CIC_COMB_DIFF_DELAY2_EN
            d2_r[wr_ch] <= d1_r[wr_ch];
`endif
        end
    end

    // Read port: plain array read, so a write on cycle N is seen on N+1.
    always_comb begin
        rd_ok_s = ({1'b0, rd_ch} < CH_LIMIT);
        if (rd_ok_s) begin
            rd_d1 = d1_r[rd_ch];
`ifdef CIC_COMB_DIFF_DELAY2_EN
            rd_d2 = d2_r[rd_ch];
`else
            rd_d2 = {W{1'b0}};
`endif
        end else begin
            rd_d1 = {W{1'b0}};
            rd_d2 = {W{1'b0}};
        end
    end

endmodule

// File: rtl/cic_comb_sub.sv
// ---------------------------------------------------------------------------
// cic_comb_sub
// One CIC comb section, time-shared over up to CIC_MAX_CHANNELS channels:
//   y[n] = x[n] - x[n-M] per channel, modulo 2^MIDDLE_WIDTH, M = 1 or 2.
// Section state is decoded every cycle from the enable mask and the system
// config state: disabled -> pass-through, config 3 -> clear history,
// otherwise run. Output latency is exactly one cycle; outputs hold their
// last value while Data_Out_Valid is low.
// Ports:
//   CLK                 in   clock (rising edge)
//   RST                 in   synchronous active-high reset
//   idx                 in   section index into CIC_NUMSECS_reg
//   state_idx_reg       in   system config state (3'd3 = clear)
//   CIC_NUMSECS_reg     in   section enable mask
//   CIC_DIFF_DELAY_reg  in   0: M=1, 1: M=2 (ignored without M=2 support)
//   Data_In             in   signed input sample
//   Data_In_Valid       in   input qualifier
//   Data_In_ChIdx       in   input channel
//   Data_Out            out  signed comb output (registered)
//   Data_Out_Valid      out  output qualifier (registered)
//   Data_Out_ChIdx      out  output channel (registered)
// Configuration macro: CIC_COMB_DIFF_DELAY2_EN enables D2 and M=2.
// ---------------------------------------------------------------------------
module cic_comb_sub
    import cic_comb_sub_pkg::*;
#(
    parameter int MIDDLE_WIDTH          = DEF_MIDDLE_WIDTH,
    parameter int CIC_MAX_CHANNELS      = DEF_MAX_CHANNELS,
    parameter int CIC_CONFIG_DATA_WIDTH = DEF_CONFIG_DATA_WIDTH
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [3:0]                       idx,
    input  logic [2:0]                       state_idx_reg,
    input  logic [CIC_CONFIG_DATA_WIDTH-1:0] CIC_NUMSECS_reg,
    input  logic                             CIC_DIFF_DELAY_reg,
    input  logic [MIDDLE_WIDTH-1:0]          Data_In,
    input  logic                             Data_In_Valid,
    input  logic [3:0]                       Data_In_ChIdx,
    output logic [MIDDLE_WIDTH-1:0]          Data_Out,
    output logic                             Data_Out_Valid,
    output logic [3:0]                       Data_Out_ChIdx
);

    localparam logic [4:0] CH_LIMIT = 5'(CIC_MAX_CHANNELS);

    comb_state_e             state_s;
    logic                    ch_ok_s;
    logic                    take_s;
    logic                    wr_en_s;
    logic                    clr_s;
    logic [MIDDLE_WIDTH-1:0] d1_s;
    logic [MIDDLE_WIDTH-1:0] d2_s;
    logic [MIDDLE_WIDTH-1:0] sub_s;
    logic [MIDDLE_WIDTH-1:0] diff_s;

`ifndef CIC_COMB_DIFF_DELAY2_EN
    // Without M=2 support the delay select and the D2 read are don't-cares.
    logic unused_s;
    assign unused_s = ^{CIC_DIFF_DELAY_reg, d2_s};
`endif

    cic_comb_delay_bank #(
        .W  (MIDDLE_WIDTH),
        .CH (CIC_MAX_CHANNELS)
    ) u_bank (
        .clk     (CLK),
        .rst     (RST),
        .clr     (clr_s),
        .wr_en   (wr_en_s),
        .wr_ch   (Data_In_ChIdx),
        .wr_data (Data_In),
        .rd_ch   (Data_In_ChIdx),
        .rd_d1   (d1_s),
        .rd_d2   (d2_s)
    );

    // State decode, sample acceptance and the wrapping difference.
    always_comb begin
        state_s = decode_state(CIC_NUMSECS_reg[idx], state_idx_reg);
        ch_ok_s = ({1'b0, Data_In_ChIdx} < CH_LIMIT);
        // Clear drops the sample; bypass forwards it without touching history.
        take_s  = Data_In_Valid && ch_ok_s && (state_s != S_CLEAR);
        wr_en_s = Data_In_Valid && ch_ok_s && (state_s == S_RUN);
        clr_s   = (state_s == S_CLEAR);
`ifdef CIC_COMB_DIFF_DELAY2_EN
        if (CIC_DIFF_DELAY_reg) begin
            sub_s = d2_s;
        end else begin
            sub_s = d1_s;
        end
`else
        sub_s = d1_s;
`endif
        // Truncating subtraction is the intended modulo-2^W CIC arithmetic.
        diff_s = Data_In - sub_s;
    end

    // Output registers: load on an accepted sample, otherwise hold data/ch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Data_Out       <= {MIDDLE_WIDTH{1'b0}};
            Data_Out_Valid <= 1'b0;
            Data_Out_ChIdx <= 4'd0;
        end else if (take_s) begin
            Data_Out_Valid <= 1'b1;
            Data_Out_ChIdx <= Data_In_ChIdx;
            if (state_s == S_OFF) begin
                Data_Out <= Data_In;
            end else begin
                Data_Out <= diff_s;
            end
        end else begin
            Data_Out_Valid <= 1'b0;
        end
    end

endmodule

// File: doc/cic_comb_sub.md
CIC_COMB_SUB -- requirements
Module: cic_comb_sub

Interface
REQ-001 Parameter MIDDLE_WIDTH, default 37, sample word width, two's complement.
REQ-002 Parameter CIC_MAX_CHANNELS, default 16, number of channel delay slots (1..16).
REQ-003 Parameter CIC_CONFIG_DATA_WIDTH, default 16, width of CIC_NUMSECS_reg.
REQ-004 CLK  in  1  single clock; all logic SHALL be rising-edge CLK.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 idx  in  4  comb section index; selects enable bit in CIC_NUMSECS_reg.
REQ-007 state_idx_reg  in  3  system config state; value 3'd3 = reconfigure/clear.
REQ-008 CIC_NUMSECS_reg  in  CIC_CONFIG_DATA_WIDTH  section-enable mask; bit idx = 1 enables this section.
REQ-009 CIC_DIFF_DELAY_reg  in  1  differential delay select: 0 = M=1, 1 = M=2.
REQ-010 Data_In  in  MIDDLE_WIDTH  signed decimated sample.
REQ-011 Data_In_Valid  in  1  single-cycle qualifier for Data_In/Data_In_ChIdx.
REQ-012 Data_In_ChIdx  in  4  channel of Data_In.
REQ-013 Data_Out  out  MIDDLE_WIDTH  signed comb output.
REQ-014 Data_Out_Valid  out  1  single-cycle qualifier for Data_Out.
REQ-015 Data_Out_ChIdx  out  4  channel of Data_Out.

Function
REQ-016 Block SHALL compute per channel c: y[n] = x[n] - x[n-M], M per CIC_DIFF_DELAY_reg.
REQ-017 Subtraction SHALL be modulo 2^MIDDLE_WIDTH (wrap, no saturation), as CIC arithmetic requires.
REQ-018 State register, re-evaluated every cycle, priority order: bit idx of CIC_NUMSECS_reg = 0 -> S_OFF; else state_idx_reg == 3'd3 -> S_CLEAR; else S_RUN.
REQ-019 S_OFF: accepted sample SHALL pass through unchanged (Data_Out = Data_In, same ChIdx) with 1-cycle latency; delay slots not updated.
REQ-020 S_CLEAR: all delay slots SHALL be zeroed each cycle; Data_Out_Valid = 0; input samples dropped.
REQ-021 S_RUN: on Data_In_Valid, cycle N+1 SHALL present Data_Out_Valid = 1, Data_Out = Data_In - D1[c] (M=1) or Data_In - D2[c] (M=2); D2[c] <= D1[c], D1[c] <= Data_In.
REQ-022 Latency SHALL be exactly 1 cycle in S_RUN and S_OFF; one sample per cycle accepted, no backpressure.
REQ-023 Data_Out/Data_Out_ChIdx SHALL hold last value when Data_Out_Valid = 0.
REQ-024 Data_In_ChIdx >= CIC_MAX_CHANNELS: sample SHALL be dropped, no output, no slot change.
REQ-025 Clear and valid in same cycle: clear wins, sample dropped.
REQ-026 Change of CIC_DIFF_DELAY_reg outside S_CLEAR SHALL take effect on next sample; history not flushed.
REQ-027 Back-to-back samples on same channel SHALL use the slot value written in the previous cycle (no read-after-write hazard).

Reset
REQ-028 RST SHALL zero all delay slots, Data_Out, Data_Out_ChIdx, Data_Out_Valid; state SHALL be S_OFF.
REQ-029 RST mid-stream SHALL discard any sample in flight; first sample after reset SHALL see zero history.

Configuration
REQ-030 Macro CIC_COMB_DIFF_DELAY2_EN defined: second slot bank D2 and M=2 support SHALL be compiled in.
REQ-031 Macro undefined: D2 absent, M fixed at 1, CIC_DIFF_DELAY_reg ignored (port retained).

Structure
REQ-032 Shared package SHALL hold state encodings (S_OFF, S_CLEAR, S_RUN), config-state constant 3'd3, default widths.
REQ-033 One sub-module cic_comb_delay_bank SHALL hold per-channel slots D1/D2 (write, read, clear-all).

Verification
REQ-034 RUN, M=1, ch0 inputs 10, 15, 7 -> outputs 10, 5, -8, each 1 cycle after valid.
REQ-035 RUN, M=2, ch3 inputs 1, 2, 3, 4 -> outputs 1, 2, 2, 2; interleaved ch5 input 100 -> 100, ch3 unaffected.
REQ-036 Wrap: W=37, history 2^36-1, input -2^36 -> output 1 (modulo wrap).
REQ-037 Clear: state_idx_reg=3 for 2 cycles with valids -> no Data_Out_Valid; next ch0 input 9 -> output 9.
REQ-038 Bypass: mask bit idx=0, input -42 ch7 -> Data_Out=-42 ch7 after 1 cycle; re-enable, ch7 input 5 -> 5.
REQ-039 RST asserted one cycle after valid on ch2 -> all outputs 0, no valid; post-reset ch2 input 6 -> 6.
